// File: rtl/mul_div_unit_if.sv
// Bus between the issue stage / register file and the iterative RV32M unit.
//   Request side : start, funct3, operand_a, operand_b, address_rd, flush
//   Response side: busy, done, write_enable, address_write, value_write
// The master modport belongs to the pipeline; the slave modport belongs to mul_div_unit.
interface mul_div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [4:0]       address_rd;
   logic             flush;
   logic             busy;
   logic             done;
   logic             write_enable;
   logic [4:0]       address_write;
   logic [WIDTH-1:0] value_write;

   modport master (
      output start, funct3, operand_a, operand_b, address_rd, flush,
      input  busy, done, write_enable, address_write, value_write
   );

   modport slave (
      input  start, funct3, operand_a, operand_b, address_rd, flush,
      output busy, done, write_enable, address_write, value_write
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Accepts an operation in IDLE, runs WIDTH iteration cycles in CALC, then spends one DONE cycle
// presenting a register-file write. Multiply is shift-add on operand magnitudes; divide is
// restoring division on magnitudes. Signs and special cases are applied when entering DONE.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - mul_div_unit_if slave modport (request operands, flush, busy and write port)
module mul_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   mul_div_unit_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [4:0]       rd_q, rd_d;
   logic [WIDTH-1:0] a_q, a_d;     // original dividend, needed for remainder-by-zero
   logic [WIDTH-1:0] bm_q, bm_d;   // multiplicand / divisor magnitude
   logic [WIDTH-1:0] hi_q, hi_d;   // product high half / partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;   // multiplier / dividend shifting into quotient
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic             div0_q, div0_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             we_q, we_d;
   logic [4:0]       addr_q, addr_d;
   logic [WIDTH-1:0] value_q, value_d;

   // One iteration of the shared datapath plus the final result formed from its output.
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [WIDTH-1:0]   hi_step, lo_step;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s;
   logic [WIDTH-1:0]   result_fin;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bm_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, bm_q};
      // Only used when div_ge, where the difference is below the divisor and fits in WIDTH.
      div_diff  = div_shift[WIDTH-1:0] - bm_q;
      if (op_q[2]) begin
         hi_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
         lo_step = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         hi_step = mul_sum[WIDTH:1];
         lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
      end

      prod   = {hi_step, lo_step};
      prod_s = (a_neg_q ^ b_neg_q) ? (~prod + 1'b1) : prod;
      quo_s  = (a_neg_q ^ b_neg_q) ? (~lo_step + 1'b1) : lo_step;
      rem_s  = a_neg_q ? (~hi_step + 1'b1) : hi_step;

      unique case (op_q)
         3'd0:                result_fin = prod_s[WIDTH-1:0];
         3'd1, 3'd2, 3'd3:    result_fin = prod_s[2*WIDTH-1:WIDTH];
         3'd4, 3'd5:          result_fin = div0_q ? '1 : (ovf_q ? MinInt : quo_s);
         default:             result_fin = div0_q ? a_q : (ovf_q ? '0 : rem_s);
      endcase
   end

   logic             a_signed, b_signed;
   logic [WIDTH-1:0] a_mag, b_mag;

   // Operand sign handling for the request currently on the bus.
   always_comb begin
      if (bus.funct3[2]) begin
         a_signed = ~bus.funct3[0];                  // DIV, REM
         b_signed = ~bus.funct3[0];
      end else begin
         a_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2);  // MULH, MULHSU
         b_signed = (bus.funct3 == 3'd1);
      end
      a_mag = (a_signed && bus.operand_a[WIDTH-1]) ? (~bus.operand_a + 1'b1) : bus.operand_a;
      b_mag = (b_signed && bus.operand_b[WIDTH-1]) ? (~bus.operand_b + 1'b1) : bus.operand_b;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      a_d     = a_q;
      bm_d    = bm_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      div0_d  = div0_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      value_d = value_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start && !bus.flush) begin
               state_d = StCalc;
               cnt_d   = '0;
               op_d    = bus.funct3;
               rd_d    = bus.address_rd;
               a_d     = bus.operand_a;
               bm_d    = b_mag;
               hi_d    = '0;
               lo_d    = a_mag;
               a_neg_d = a_signed && bus.operand_a[WIDTH-1];
               b_neg_d = b_signed && bus.operand_b[WIDTH-1];
               div0_d  = (bus.operand_b == '0);
               ovf_d   = bus.funct3[2] && !bus.funct3[0] && (bus.operand_a == MinInt) &&
                         (bus.operand_b == '1);
            end
         end
         StCalc: begin
            if (bus.flush) begin
               state_d = StIdle;
            end else begin
               hi_d  = hi_step;
               lo_d  = lo_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  we_d    = (rd_q != 5'd0);
                  addr_d  = rd_q;
                  value_d = result_fin;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         bm_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         bm_q    <= bm_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         div0_q  <= div0_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         value_q <= value_d;
      end
   end

   // A flush landing in the DONE cycle suppresses the write in that same cycle.
   assign bus.busy          = busy_q;
   assign bus.done          = done_q & ~bus.flush;
   assign bus.write_enable  = we_q & ~bus.flush;
   assign bus.address_write = addr_q;
   assign bus.value_write   = value_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: table of directed vectors plus hand-written
// sequences for held start, flush in CALC/DONE/IDLE and reset mid-operation.
module tb_mul_div_unit;

   localparam int unsigned WIDTH = 32;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

   mul_div_unit #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   // Launch one op, scramble the inputs after the accept edge, then check timing and result.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input string tag);
      int          done_cyc;
      int          done_cnt;
      int          busy_bad;
      logic        we_s;
      logic [4:0]  ad_s;
      logic [31:0] v_s;
      done_cyc = -1;
      done_cnt = 0;
      busy_bad = 0;
      we_s     = 1'b0;
      ad_s     = '0;
      v_s      = '0;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = f;
      bus.operand_a  = a;
      bus.operand_b  = b;
      bus.address_rd = rd;
      @(posedge clk);
      #1;
      bus.start      = 1'b0;
      bus.funct3     = ~f;
      bus.operand_a  = ~a;
      bus.operand_b  = a ^ b ^ 32'h5A5A_5A5A;
      bus.address_rd = ~rd;
      for (int cyc = 1; cyc <= WIDTH + 1; cyc++) begin
         @(negedge clk);
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            we_s     = bus.write_enable;
            ad_s     = bus.address_write;
            v_s      = bus.value_write;
         end
      end
      @(negedge clk);
      chk({tag, " done_cycle"}, done_cyc, WIDTH + 1);
      chk({tag, " done_count"}, done_cnt, 1);
      chk({tag, " value"}, v_s, exp);
      chk({tag, " address"}, {27'd0, ad_s}, {27'd0, rd});
      chk({tag, " write_enable"}, {31'd0, we_s}, {31'd0, rd != 5'd0});
      chk({tag, " busy_window"}, busy_bad, 0);
      chk({tag, " busy_fall"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          rises[$];
      int          exp_r[3];
      logic        prev;
      int          bad;

      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      bus.start      = 1'b0;
      bus.funct3     = '0;
      bus.operand_a  = '0;
      bus.operand_b  = '0;
      bus.address_rd = '0;
      bus.flush      = 1'b0;

      vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB});
      vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000});
      vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE});
      vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF});
      vecs.push_back('{3'd2, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'hC000_0000});
      vecs.push_back('{3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 5'd6,  32'hFFFF_FFFF});
      vecs.push_back('{3'd3, 32'h8000_0000, 32'h0000_0004, 5'd7,  32'h0000_0002});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFD});
      vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF});
      vecs.push_back('{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD});
      vecs.push_back('{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd11, 32'h0000_0001});
      vecs.push_back('{3'd5, 32'd100,       32'd7,         5'd12, 32'd14});
      vecs.push_back('{3'd7, 32'd100,       32'd7,         5'd13, 32'd2});
      vecs.push_back('{3'd4, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF});
      vecs.push_back('{3'd7, 32'd5,         32'd0,         5'd15, 32'd5});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFFF});
      vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFF9});
      vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000});
      vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000});
      vecs.push_back('{3'd0, 32'd6,         32'd7,         5'd0,  32'd42});

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset done", {31'd0, bus.done}, 32'd0);
      chk("reset write_enable", {31'd0, bus.write_enable}, 32'd0);
      chk("reset address_write", {27'd0, bus.address_write}, 32'd0);
      chk("reset value_write", bus.value_write, 32'd0);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp,
               $sformatf("vec%0d", i));
      end

      // start held high: accepts at cycles 0, 34, 68, so busy rises in 1, 35, 69
      exp_r = '{1, 35, 69};
      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = 3'd0;
      bus.operand_a  = 32'd3;
      bus.operand_b  = 32'd4;
      bus.address_rd = 5'd1;
      @(posedge clk);
      prev = 1'b0;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         @(negedge clk);
         if (bus.busy && !prev) rises.push_back(cyc);
         prev = bus.busy;
      end
      bus.start = 1'b0;
      chk("held rise_count", rises.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("held rise%0d", i), (i < rises.size()) ? rises[i] : -1, exp_r[i]);
      end
      for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
      chk("held drain", {31'd0, bus.busy}, 32'd0);

      // flush at cycle 10
      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = 3'd0;
      bus.operand_a  = 32'd6;
      bus.operand_b  = 32'd7;
      bus.address_rd = 5'd9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_calc busy", {31'd0, bus.busy}, 32'd0);
      bad = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.write_enable !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      chk("flush_calc quiet", bad, 0);

      // flush in the DONE cycle
      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = 3'd0;
      bus.operand_a  = 32'd6;
      bus.operand_b  = 32'd7;
      bus.address_rd = 5'd3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int cyc = 1; cyc <= WIDTH; cyc++) @(negedge clk);
      @(posedge clk);
      #1 bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_done busy", {31'd0, bus.busy}, 32'd1);
      chk("flush_done write_enable", {31'd0, bus.write_enable}, 32'd0);
      chk("flush_done done", {31'd0, bus.done}, 32'd0);
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_done busy_fall", {31'd0, bus.busy}, 32'd0);
      chk("flush_done no_late_write", {31'd0, bus.write_enable}, 32'd0);

      // flush in IDLE blocks acceptance
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bad = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) bad++;
      end
      chk("flush_idle blocked", bad, 0);

      // reset pulse at cycle 20: outputs clear at once, then a new op runs normally
      @(negedge clk);
      bus.start      = 1'b1;
      bus.funct3     = 3'd0;
      bus.operand_a  = 32'd6;
      bus.operand_b  = 32'd7;
      bus.address_rd = 5'd3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst busy", {31'd0, bus.busy}, 32'd0);
      chk("rst done", {31'd0, bus.done}, 32'd0);
      chk("rst write_enable", {31'd0, bus.write_enable}, 32'd0);
      chk("rst address_write", {27'd0, bus.address_write}, 32'd0);
      chk("rst value_write", bus.value_write, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      chk("rst quiet", bad, 0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
